// File: rtl/decode_queue.sv
// Buffered RV32I/RV32E decode stage: instructions are decoded on enqueue and
// the decoded bundles are held in a DEPTH-entry FIFO in front of execute.
module decode_queue #(
    parameter int unsigned DEPTH = 2,
    parameter bit          RV32E = 1'b0,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [31:0]      i_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_pc,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [4:0]       o_rd,
    output logic [31:0]      o_imm,
    output logic [3:0]       o_alu_op_sel,
    output logic             o_alu_sub,
    output logic             o_alu_arith,
    output logic             o_mem_we,
    output logic [2:0]       o_wb_sel,
    output logic             o_wb_we,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_ARIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ENV    = 7'b1110011;

    localparam logic [2:0] WB_ALU = 3'b001;
    localparam logic [2:0] WB_MEM = 3'b010;
    localparam logic [2:0] WB_PC4 = 3'b100;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op_sel;
        logic        alu_sub;
        logic        alu_arith;
        logic        mem_we;
        logic [2:0]  wb_sel;
        logic        wb_we;
        logic        illegal;
    } bundle_t;

    // instruction fields
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = i_inst[6:0];
    assign f3     = i_inst[14:12];
    assign f7     = i_inst[31:25];
    assign rs1_f  = i_inst[19:15];
    assign rs2_f  = i_inst[24:20];
    assign rd_f   = i_inst[11:7];
    assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                     i_inst[11:8], 1'b0};
    assign imm_u  = {i_inst[31:12], 12'h000};
    assign imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                     i_inst[30:21], 1'b0};

    // decode intermediates
    logic        legal_op;
    logic        legal;
    logic        reg_bad;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        is_store;
    logic [31:0] imm;
    logic [3:0]  f3_op_sel;
    logic [3:0]  op_sel;
    logic [2:0]  wb_sel_raw;
    bundle_t     dec;

    // ALU unit select implied by funct3 for register and immediate ALU ops
    always_comb begin
        f3_op_sel = 4'b0001;
        case (f3)
            3'b010, 3'b011:         f3_op_sel = 4'b0010;
            3'b100, 3'b110, 3'b111: f3_op_sel = 4'b0100;
            3'b001, 3'b101:         f3_op_sel = 4'b1000;
            default:                f3_op_sel = 4'b0001;
        endcase
    end

    // per-opcode legality, register usage, immediate format and writeback source
    always_comb begin
        legal_op   = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        is_store   = 1'b0;
        imm        = 32'h0;
        op_sel     = 4'b0001;
        wb_sel_raw = 3'b000;
        case (opcode)
            OP_ARITH: begin
                legal_op   = (f7 == F7_ZERO) ||
                             ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                use_rd     = 1'b1;
                op_sel     = f3_op_sel;
                wb_sel_raw = WB_ALU;
            end
            OP_ARIMM: begin
                if (f3 == 3'b001)      legal_op = (f7 == F7_ZERO);
                else if (f3 == 3'b101) legal_op = (f7 == F7_ZERO) || (f7 == F7_ALT);
                else                   legal_op = 1'b1;
                use_rs1    = 1'b1;
                use_rd     = 1'b1;
                imm        = imm_i;
                op_sel     = f3_op_sel;
                wb_sel_raw = WB_ALU;
            end
            OP_LOAD: begin
                legal_op   = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                use_rs1    = 1'b1;
                use_rd     = 1'b1;
                imm        = imm_i;
                wb_sel_raw = WB_MEM;
            end
            OP_STORE: begin
                legal_op = (f3 <= 3'b010);
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                is_store = 1'b1;
                imm      = imm_s;
            end
            OP_BRANCH: begin
                legal_op = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                imm      = imm_b;
            end
            OP_JALR: begin
                legal_op   = (f3 == 3'b000);
                use_rs1    = 1'b1;
                use_rd     = 1'b1;
                imm        = imm_i;
                wb_sel_raw = WB_PC4;
            end
            OP_JAL: begin
                legal_op   = 1'b1;
                use_rd     = 1'b1;
                imm        = imm_j;
                wb_sel_raw = WB_PC4;
            end
            OP_LUI, OP_AUIPC: begin
                legal_op   = 1'b1;
                use_rd     = 1'b1;
                imm        = imm_u;
                wb_sel_raw = WB_ALU;
            end
            OP_ENV: begin
                legal_op = (i_inst == 32'h0000_0073) || (i_inst == 32'h0010_0073);
            end
            default: begin
                legal_op = 1'b0;
            end
        endcase
    end

    // RV32E rejects any referenced register above x15
    assign reg_bad = (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]);
    assign legal   = legal_op && !(RV32E && reg_bad);

    // assemble the bundle; illegal entries are forced to have no side effects
    always_comb begin
        dec            = '0;
        dec.pc         = i_pc;
        dec.rs1        = use_rs1 ? rs1_f : 5'd0;
        dec.rs2        = use_rs2 ? rs2_f : 5'd0;
        dec.rd         = use_rd ? rd_f : 5'd0;
        dec.imm        = imm;
        dec.alu_op_sel = op_sel;
        dec.alu_sub    = (opcode == OP_ARITH) && (f3 == 3'b000) && f7[5];
        dec.alu_arith  = ((opcode == OP_ARITH) || (opcode == OP_ARIMM)) &&
                         (f3 == 3'b101) && f7[5];
        dec.mem_we     = legal && is_store;
        dec.wb_sel     = legal ? wb_sel_raw : 3'b000;
        dec.wb_we      = legal && use_rd && (rd_f != 5'd0);
        dec.illegal    = !legal;
    end

    // queue storage and control
    bundle_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    bundle_t          head;

    assign o_ready = (count != CNT_W'(DEPTH));
    assign o_valid = (count != CNT_W'(0));
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;
    assign o_count = count;

    // write decoded bundle at the write pointer
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    // pointer and occupancy update; flush wins over push and pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // head bundle, zeroed whenever nothing is valid
    assign head         = o_valid ? mem[rd_ptr] : '0;
    assign o_pc         = head.pc;
    assign o_rs1        = head.rs1;
    assign o_rs2        = head.rs2;
    assign o_rd         = head.rd;
    assign o_imm        = head.imm;
    assign o_alu_op_sel = head.alu_op_sel;
    assign o_alu_sub    = head.alu_sub;
    assign o_alu_arith  = head.alu_arith;
    assign o_mem_we     = head.mem_we;
    assign o_wb_sel     = head.wb_sel;
    assign o_wb_we      = head.wb_we;
    assign o_illegal    = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: scoreboard of expected head bundles.
module tb_decode_queue;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        sub;
        logic        arith;
        logic        mem_we;
        logic [2:0]  wb_sel;
        logic        wb_we;
        logic        illegal;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    // main instance: DEPTH=2, RV32I
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [31:0] o_imm;
    logic [3:0]  o_op;
    logic        o_sub, o_arith, o_mem_we, o_wb_we, o_illegal;
    logic [2:0]  o_wb_sel;
    logic [1:0]  o_count;

    // second instance: DEPTH=4, RV32E
    logic        e_in_valid = 1'b0;
    logic        e_in_ready;
    logic [31:0] e_inst = 32'h0;
    logic [31:0] e_pc_in = 32'h0;
    logic        e_out_valid;
    logic        e_out_ready = 1'b0;
    logic [31:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_imm;
    logic [3:0]  e_op;
    logic        e_sub, e_arith, e_mem_we, e_wb_we, e_illegal;
    logic [2:0]  e_wb_sel;
    logic [2:0]  e_count;

    int checks = 0;
    int errors = 0;
    bundle_t sb[$];

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(2), .RV32E(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_valid(in_valid), .o_ready(in_ready), .i_inst(inst), .i_pc(pc),
        .o_valid(out_valid), .i_ready(out_ready), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm),
        .o_alu_op_sel(o_op), .o_alu_sub(o_sub), .o_alu_arith(o_arith),
        .o_mem_we(o_mem_we), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_illegal(o_illegal), .o_count(o_count)
    );

    decode_queue #(.DEPTH(4), .RV32E(1'b1)) dut_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0),
        .i_valid(e_in_valid), .o_ready(e_in_ready), .i_inst(e_inst), .i_pc(e_pc_in),
        .o_valid(e_out_valid), .i_ready(e_out_ready), .o_pc(e_pc),
        .o_rs1(e_rs1), .o_rs2(e_rs2), .o_rd(e_rd), .o_imm(e_imm),
        .o_alu_op_sel(e_op), .o_alu_sub(e_sub), .o_alu_arith(e_arith),
        .o_mem_we(e_mem_we), .o_wb_sel(e_wb_sel), .o_wb_we(e_wb_we),
        .o_illegal(e_illegal), .o_count(e_count)
    );

    function automatic bundle_t mk(input logic [31:0] p, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] d,
                                   input logic [31:0] im, input logic [3:0] op,
                                   input logic sb_, input logic ar, input logic mw,
                                   input logic [2:0] ws, input logic we, input logic il);
        bundle_t b;
        b.valid = 1'b1; b.pc = p; b.rs1 = r1; b.rs2 = r2; b.rd = d; b.imm = im;
        b.op = op; b.sub = sb_; b.arith = ar; b.mem_we = mw; b.wb_sel = ws;
        b.wb_we = we; b.illegal = il;
        return b;
    endfunction

    function automatic bundle_t observe();
        bundle_t b;
        b.valid = out_valid; b.pc = o_pc; b.rs1 = o_rs1; b.rs2 = o_rs2; b.rd = o_rd;
        b.imm = o_imm; b.op = o_op; b.sub = o_sub; b.arith = o_arith;
        b.mem_we = o_mem_we; b.wb_sel = o_wb_sel; b.wb_we = o_wb_we; b.illegal = o_illegal;
        return b;
    endfunction

    function automatic bundle_t observe_e();
        bundle_t b;
        b.valid = e_out_valid; b.pc = e_pc; b.rs1 = e_rs1; b.rs2 = e_rs2; b.rd = e_rd;
        b.imm = e_imm; b.op = e_op; b.sub = e_sub; b.arith = e_arith;
        b.mem_we = e_mem_we; b.wb_sel = e_wb_sel; b.wb_we = e_wb_we; b.illegal = e_illegal;
        return b;
    endfunction

    task automatic test_reset();
        bundle_t got;
        repeat (2) @(negedge clk);
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_bundle: got %h required 0", got);
        end
        checks++;
        if ({o_count, in_ready, e_count, e_in_ready} !== {2'd0, 1'b1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_count: got cnt=%0d rdy=%b ecnt=%0d erdy=%b required 0 1 0 1",
                     o_count, in_ready, e_count, e_in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] insts [7];
        bundle_t     exps [7];
        bundle_t     got, exp;
        insts[0] = 32'h00510093; exps[0] = mk(32'h100, 5'd2, 5'd0, 5'd1, 32'd5, 4'b0001, 0, 0, 0, 3'b001, 1, 0);
        insts[1] = 32'h402081B3; exps[1] = mk(32'h104, 5'd1, 5'd2, 5'd3, 32'd0, 4'b0001, 1, 0, 0, 3'b001, 1, 0);
        insts[2] = 32'h40335293; exps[2] = mk(32'h108, 5'd6, 5'd0, 5'd5, 32'h403, 4'b1000, 0, 1, 0, 3'b001, 1, 0);
        insts[3] = 32'h0020A223; exps[3] = mk(32'h10C, 5'd1, 5'd2, 5'd0, 32'd4, 4'b0001, 0, 0, 1, 3'b000, 0, 0);
        insts[4] = 32'h00208833; exps[4] = mk(32'h110, 5'd1, 5'd2, 5'd16, 32'd0, 4'b0001, 0, 0, 0, 3'b001, 1, 0);
        insts[5] = 32'h123453B7; exps[5] = mk(32'h114, 5'd0, 5'd0, 5'd7, 32'h12345000, 4'b0001, 0, 0, 0, 3'b001, 1, 0);
        insts[6] = 32'hFE208EE3; exps[6] = mk(32'h118, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 4'b0001, 0, 0, 0, 3'b000, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = observe();
                exp = sb.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL decode_%0d: got %h required %h", i - 1, got, exp);
                end
            end
            if (i < 7) begin
                in_valid = 1'b1;
                inst = insts[i];
                pc = 32'h100 + 32'(4 * i);
                sb.push_back(exps[i]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({out_valid, o_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL decode_drain: got valid=%b cnt=%0d required 0 0", out_valid, o_count);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] insts [5];
        bundle_t     exps [5];
        bundle_t     got, exp;
        insts[0] = 32'h00000000; exps[0] = mk(32'h200, 5'd0, 5'd0, 5'd0, 32'd0, 4'b0001, 0, 0, 0, 3'b000, 0, 1);
        insts[1] = 32'h02000033; exps[1] = mk(32'h204, 5'd0, 5'd0, 5'd0, 32'd0, 4'b0001, 0, 0, 0, 3'b000, 0, 1);
        insts[2] = 32'h00200073; exps[2] = mk(32'h208, 5'd0, 5'd0, 5'd0, 32'd0, 4'b0001, 0, 0, 0, 3'b000, 0, 1);
        insts[3] = 32'h00003083; exps[3] = mk(32'h20C, 5'd0, 5'd0, 5'd1, 32'd0, 4'b0001, 0, 0, 0, 3'b000, 0, 1);
        insts[4] = 32'h40001013; exps[4] = mk(32'h210, 5'd0, 5'd0, 5'd0, 32'h400, 4'b1000, 0, 0, 0, 3'b000, 0, 1);
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = observe();
                exp = sb.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL illegal_%0d: got %h required %h", i - 1, got, exp);
                end
            end
            if (i < 5) begin
                in_valid = 1'b1;
                inst = insts[i];
                pc = 32'h200 + 32'(4 * i);
                sb.push_back(exps[i]);
            end else begin
                in_valid = 1'b0;
            end
        end
        // RV32E: x16 is rejected, x15 is accepted
        e_out_ready = 1'b0;
        e_in_valid = 1'b1; e_inst = 32'h00208833; e_pc_in = 32'h300;
        @(negedge clk);
        e_inst = 32'h002087B3; e_pc_in = 32'h304;
        got = observe_e();
        exp = mk(32'h300, 5'd1, 5'd2, 5'd16, 32'd0, 4'b0001, 0, 0, 0, 3'b000, 0, 1);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rv32e_x16: got %h required %h", got, exp);
        end
        e_out_ready = 1'b1;
        @(negedge clk);
        e_in_valid = 1'b0;
        got = observe_e();
        exp = mk(32'h304, 5'd1, 5'd2, 5'd15, 32'd0, 4'b0001, 0, 0, 0, 3'b001, 1, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rv32e_x15: got %h required %h", got, exp);
        end
        @(negedge clk);
        checks++;
        if ({e_out_valid, e_count, e_in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rv32e_drain: got valid=%b cnt=%0d rdy=%b required 0 0 1",
                     e_out_valid, e_count, e_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        bundle_t got, exp;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h00108093; pc = 32'h400;
        sb.push_back(mk(32'h400, 5'd1, 5'd0, 5'd1, 32'd1, 4'b0001, 0, 0, 0, 3'b001, 1, 0));
        @(negedge clk);
        checks++;
        if ({out_valid, o_count, in_ready} !== {1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b cnt=%0d rdy=%b required 1 1 1",
                     out_valid, o_count, in_ready);
        end
        inst = 32'h00210113; pc = 32'h404;
        sb.push_back(mk(32'h404, 5'd2, 5'd0, 5'd2, 32'd2, 4'b0001, 0, 0, 0, 3'b001, 1, 0));
        @(negedge clk);
        checks++;
        if ({o_count, in_ready} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_full: got cnt=%0d rdy=%b required 2 0", o_count, in_ready);
        end
        inst = 32'h00318193; pc = 32'h408;
        @(negedge clk);
        checks++;
        if ({o_count, in_ready} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_held: got cnt=%0d rdy=%b required 2 0", o_count, in_ready);
        end
        // full queue: this edge pops the head but must not accept the waiting word
        out_ready = 1'b1;
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_head0: got %h required %h", got, exp);
        end
        @(negedge clk);
        checks++;
        if ({o_count, in_ready} !== {2'd1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_no_push_when_full: got cnt=%0d rdy=%b required 1 1", o_count, in_ready);
        end
        sb.push_back(mk(32'h408, 5'd3, 5'd0, 5'd3, 32'd3, 4'b0001, 0, 0, 0, 3'b001, 1, 0));
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_head1: got %h required %h", got, exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
        got = observe(); exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_head2_wrapped: got %h required %h", got, exp);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, o_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b cnt=%0d required 0 0", out_valid, o_count);
        end
    endtask

    task automatic test_flush();
        bundle_t got, exp;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h00108093; pc = 32'h500;
        @(negedge clk);
        inst = 32'h00210113; pc = 32'h504;
        @(negedge clk);
        checks++;
        if (o_count !== 2'd2) begin
            errors++;
            $display("FAIL flush_prefill: got cnt=%0d required 2", o_count);
        end
        flush = 1'b1; inst = 32'h00318193; pc = 32'h508;
        sb.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        got = observe();
        checks++;
        if ({got, o_count} !== {bundle_t'('0), 2'd0}) begin
            errors++;
            $display("FAIL flush_empty: got %h cnt=%0d required 0 0", got, o_count);
        end
        in_valid = 1'b1; inst = 32'h00510093; pc = 32'h50C;
        sb.push_back(mk(32'h50C, 5'd2, 5'd0, 5'd1, 32'd5, 4'b0001, 0, 0, 0, 3'b001, 1, 0));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        got = observe(); exp = sb.pop_front();
        checks++;
        if ({got, o_count} !== {exp, 2'd1}) begin
            errors++;
            $display("FAIL flush_after: got %h cnt=%0d required %h 1", got, o_count, exp);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, o_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL flush_drain: got valid=%b cnt=%0d required 0 0", out_valid, o_count);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h00108093; pc = 32'h600;
        @(negedge clk);
        inst = 32'h00210113; pc = 32'h604;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, o_count} !== {1'b1, 2'd2}) begin
            errors++;
            $display("FAIL areset_prefill: got valid=%b cnt=%0d required 1 2", out_valid, o_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, o_count, in_ready, o_pc} !== {1'b0, 2'd0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL areset_immediate: got valid=%b cnt=%0d rdy=%b pc=%h required 0 0 1 0",
                     out_valid, o_count, in_ready, o_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
